// File: rtl/cache_pkg.sv
// Shared constants, types and FSM states for the cache replacement controller.
package cache_pkg;

    localparam int CHAN_COUNT = 8;
    localparam int CHAN_WIDTH = 3;
    localparam int LRU_WIDTH  = 3;

    localparam logic [LRU_WIDTH-1:0] MAX_LRU = 3'b111;

    typedef logic [CHAN_WIDTH-1:0] chan_t;
    typedef logic [LRU_WIDTH-1:0]  age_t;
    typedef age_t [CHAN_COUNT-1:0] age_vec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WB,
        ST_FILL,
        ST_RESP
    } state_t;

endpackage

// File: rtl/cache_replace_ctrl_if.sv
// Request, writeback, fill and response signals of the replacement controller.
// The slave modport is the controller; the master modport is its environment
// (cache front end plus memory interface).
interface cache_replace_ctrl_if
    import cache_pkg::*;
#(
    parameter int SET_WIDTH = 4,
    parameter int TAG_WIDTH = 8
) ();

    logic                 req_valid;
    logic                 req_ready;
    logic [SET_WIDTH-1:0] req_set;
    logic [TAG_WIDTH-1:0] req_tag;
    logic                 req_write;

    logic                 wb_valid;
    logic                 wb_ready;
    logic [SET_WIDTH-1:0] wb_set;
    logic [TAG_WIDTH-1:0] wb_tag;
    chan_t                wb_chan;

    logic                 fill_valid;
    logic                 fill_ready;
    logic [SET_WIDTH-1:0] fill_set;
    logic [TAG_WIDTH-1:0] fill_tag;
    chan_t                fill_chan;

    logic                 resp_valid;
    logic                 resp_hit;
    chan_t                resp_chan;

    modport slave (
        input  req_valid, req_set, req_tag, req_write, wb_ready, fill_ready,
        output req_ready, wb_valid, wb_set, wb_tag, wb_chan,
               fill_valid, fill_set, fill_tag, fill_chan,
               resp_valid, resp_hit, resp_chan
    );

    modport master (
        output req_valid, req_set, req_tag, req_write, wb_ready, fill_ready,
        input  req_ready, wb_valid, wb_set, wb_tag, wb_chan,
               fill_valid, fill_set, fill_tag, fill_chan,
               resp_valid, resp_hit, resp_chan
    );

endinterface

// File: rtl/lru_age_update.sv
// True-LRU age update for one set: the touched channel becomes youngest and
// every channel younger than it ages by one, so the ages stay a permutation.
module lru_age_update
    import cache_pkg::*;
(
    input  age_vec_t age_in,
    input  chan_t    chan,
    output age_vec_t age_out
);

    age_t touched_age;

    // Age every channel strictly younger than the touched one; zero the touched one.
    always_comb begin
        touched_age = age_in[chan];
        for (int i = 0; i < CHAN_COUNT; i++) begin
            if (chan_t'(i) == chan) begin
                age_out[i] = '0;
            end else if (age_in[i] < touched_age) begin
                age_out[i] = age_in[i] + age_t'(1);
            end else begin
                age_out[i] = age_in[i];
            end
        end
    end

endmodule

// File: rtl/cache_replace_ctrl.sv
// Replacement controller for one 8-channel set-associative array: serialises
// each request through lookup, optional dirty writeback, fill and response.
module cache_replace_ctrl
    import cache_pkg::*;
#(
    parameter int SET_COUNT = 16,
    parameter int SET_WIDTH = 4,
    parameter int TAG_WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    cache_replace_ctrl_if.slave bus
);

    state_t state_q, state_d;

    logic [SET_WIDTH-1:0] set_q;
    logic [TAG_WIDTH-1:0] req_tag_q;
    logic                 write_q;
    chan_t                victim_q;
    logic [TAG_WIDTH-1:0] victim_tag_q;
    logic                 resp_hit_q;
    chan_t                resp_chan_q;

    logic [TAG_WIDTH-1:0]  tag_mem   [SET_COUNT][CHAN_COUNT];
    logic [CHAN_COUNT-1:0] valid_mem [SET_COUNT];
    logic [CHAN_COUNT-1:0] mod_mem   [SET_COUNT];
    age_vec_t              age_mem   [SET_COUNT];

    age_vec_t              set_ages;
    age_vec_t              new_ages;
    logic [CHAN_COUNT-1:0] match;
    logic                  hit;
    chan_t                 hit_chan;
    chan_t                 victim_chan;
    chan_t                 touch_chan;
    logic                  victim_dirty;

    // Tag compare and victim search over the latched set.
    always_comb begin
        set_ages    = age_mem[set_q];
        match       = '0;
        hit_chan    = '0;
        victim_chan = '0;
        for (int i = 0; i < CHAN_COUNT; i++) begin
            match[i] = valid_mem[set_q][i] && (tag_mem[set_q][i] == req_tag_q);
            if (match[i]) begin
                hit_chan = chan_t'(i);
            end
            if (set_ages[i] == MAX_LRU) begin
                victim_chan = chan_t'(i);
            end
        end
        hit          = $onehot(match);
        victim_dirty = valid_mem[set_q][victim_chan] && mod_mem[set_q][victim_chan];
        touch_chan   = (state_q == ST_LOOKUP) ? hit_chan : victim_q;
    end

    // Shared age updater: hit channel during LOOKUP, victim channel during FILL.
    lru_age_update u_lru (
        .age_in  (set_ages),
        .chan    (touch_chan),
        .age_out (new_ages)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
        // independent of the order in which always blocks are evaluated.
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.req_valid)  state_d = ST_LOOKUP;
            ST_LOOKUP: begin
                if (hit)               state_d = ST_RESP;
                else if (victim_dirty) state_d = ST_WB;
                else                   state_d = ST_FILL;
            end
            ST_WB:     if (bus.wb_ready)   state_d = ST_FILL;
            ST_FILL:   if (bus.fill_ready) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request fields, victim capture and per-set array updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            set_q        <= '0;
            req_tag_q    <= '0;
            write_q      <= 1'b0;
            victim_q     <= '0;
            victim_tag_q <= '0;
            resp_hit_q   <= 1'b0;
            resp_chan_q  <= '0;
            // NOTE: the array is reset explicitly because ages must restart as the
            // permutation 0..7; this keeps it in flops rather than a RAM macro.
            for (int s = 0; s < SET_COUNT; s++) begin
                valid_mem[s] <= '0;
                mod_mem[s]   <= '0;
                for (int w = 0; w < CHAN_COUNT; w++) begin
                    tag_mem[s][w] <= '0;
                    age_mem[s][w] <= age_t'(w);
                end
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        set_q     <= bus.req_set;
                        req_tag_q <= bus.req_tag;
                        write_q   <= bus.req_write;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        age_mem[set_q]          <= new_ages;
                        mod_mem[set_q][hit_chan] <= mod_mem[set_q][hit_chan] | write_q;
                        resp_hit_q              <= 1'b1;
                        resp_chan_q             <= hit_chan;
                    end else begin
                        victim_q     <= victim_chan;
                        victim_tag_q <= tag_mem[set_q][victim_chan];
                        resp_hit_q   <= 1'b0;
                        resp_chan_q  <= victim_chan;
                    end
                end
                ST_WB: begin
                    if (bus.wb_ready) begin
                        mod_mem[set_q][victim_q] <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (bus.fill_ready) begin
                        tag_mem[set_q][victim_q]   <= req_tag_q;
                        valid_mem[set_q][victim_q] <= 1'b1;
                        mod_mem[set_q][victim_q]   <= write_q;
                        age_mem[set_q]             <= new_ages;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state and fields; data is zero when not valid.
    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.wb_valid   = (state_q == ST_WB);
    assign bus.wb_set     = bus.wb_valid ? set_q        : '0;
    assign bus.wb_tag     = bus.wb_valid ? victim_tag_q : '0;
    assign bus.wb_chan    = bus.wb_valid ? victim_q     : '0;
    assign bus.fill_valid = (state_q == ST_FILL);
    assign bus.fill_set   = bus.fill_valid ? set_q     : '0;
    assign bus.fill_tag   = bus.fill_valid ? req_tag_q : '0;
    assign bus.fill_chan  = bus.fill_valid ? victim_q  : '0;
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_hit   = bus.resp_valid ? resp_hit_q  : 1'b0;
    assign bus.resp_chan  = bus.resp_valid ? resp_chan_q : '0;

endmodule

// File: tb/tb_cache_replace_ctrl.sv
// Directed bench for cache_replace_ctrl: table of requests with hand-computed
// outcomes plus sequences for writeback stall, set isolation and mid-fill reset.
module tb_cache_replace_ctrl;
    import cache_pkg::*;

    typedef struct {
        logic [3:0] set;
        logic [7:0] tag;
        logic       wr;
        logic       hit;
        logic [2:0] chan;
        logic       wb;
        logic [7:0] wb_tag;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests  = 0;
    int   failed = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    cache_replace_ctrl_if #(.SET_WIDTH(4), .TAG_WIDTH(8)) bus ();

    cache_replace_ctrl #(
        .SET_COUNT (16),
        .SET_WIDTH (4),
        .TAG_WIDTH (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_perm();
        logic       bad;
        logic [7:0] seen;
        bad = 1'b0;
        for (int s = 0; s < 16; s++) begin
            seen = '0;
            for (int w = 0; w < 8; w++) seen[dut.age_mem[s][w]] = 1'b1;
            if (seen != 8'hFF) bad = 1'b1;
        end
        check("age_permutation", bad, 1'b0);
    endtask

    task automatic add(input logic [3:0] s, input logic [7:0] t, input logic wr,
                       input logic h, input logic [2:0] c, input logic wb, input logic [7:0] wt);
        vecs.push_back('{set: s, tag: t, wr: wr, hit: h, chan: c, wb: wb, wb_tag: wt});
    endtask

    // Issue one request from a negedge and follow it to the response.
    task automatic issue(input logic [3:0] set, input logic [7:0] tag, input logic wr,
                         input logic exp_hit, input logic [2:0] exp_chan,
                         input logic exp_wb, input logic [7:0] exp_wb_tag,
                         input int wb_hold, input int fill_hold);
        int         edges, wb_cnt, fill_cnt, exp_lat;
        logic       done, saw_wb, saw_fill, ready_bad, wb_unstable, fill_unstable, got_hit;
        logic [3:0] wset, fset;
        logic [7:0] wtag, ftag;
        logic [2:0] wchan, fchan, got_chan;
        edges = 0; wb_cnt = 0; fill_cnt = 0;
        done = 0; saw_wb = 0; saw_fill = 0; ready_bad = 0;
        wb_unstable = 0; fill_unstable = 0; got_hit = 0; got_chan = '0;
        wset = '0; fset = '0; wtag = '0; ftag = '0; wchan = '0; fchan = '0;
        bus.req_valid  = 1'b1;
        bus.req_set    = set;
        bus.req_tag    = tag;
        bus.req_write  = wr;
        bus.wb_ready   = (wb_hold == 0);
        bus.fill_ready = (fill_hold == 0);
        while (!done && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.req_ready) ready_bad = 1'b1;
            if (bus.wb_valid) begin
                if (!saw_wb) begin
                    saw_wb = 1'b1; wset = bus.wb_set; wtag = bus.wb_tag; wchan = bus.wb_chan;
                end else if ({bus.wb_set, bus.wb_tag, bus.wb_chan} !== {wset, wtag, wchan}) begin
                    wb_unstable = 1'b1;
                end
                wb_cnt++;
                if (wb_cnt > wb_hold) bus.wb_ready = 1'b1;
            end
            if (bus.fill_valid) begin
                if (!saw_fill) begin
                    saw_fill = 1'b1; fset = bus.fill_set; ftag = bus.fill_tag; fchan = bus.fill_chan;
                end else if ({bus.fill_set, bus.fill_tag, bus.fill_chan} !== {fset, ftag, fchan}) begin
                    fill_unstable = 1'b1;
                end
                fill_cnt++;
                if (fill_cnt > fill_hold) bus.fill_ready = 1'b1;
            end
            if (bus.resp_valid) begin
                done = 1'b1; got_hit = bus.resp_hit; got_chan = bus.resp_chan;
            end
        end
        bus.wb_ready   = 1'b0;
        bus.fill_ready = 1'b0;
        exp_lat = 2 + (exp_wb ? 1 + wb_hold : 0) + (exp_hit ? 0 : 1 + fill_hold);
        check("resp_seen", done, 1'b1);
        check("resp_latency", edges, exp_lat);
        check("resp_hit", got_hit, exp_hit);
        check("resp_chan", got_chan, exp_chan);
        check("req_ready_low_busy", ready_bad, 1'b0);
        check("wb_seen", saw_wb, exp_wb);
        check("fill_seen", saw_fill, !exp_hit);
        if (exp_wb) begin
            check("wb_set", wset, set);
            check("wb_tag", wtag, exp_wb_tag);
            check("wb_chan", wchan, exp_chan);
            check("wb_stable", wb_unstable, 1'b0);
        end
        if (!exp_hit) begin
            check("fill_set", fset, set);
            check("fill_tag", ftag, tag);
            check("fill_chan", fchan, exp_chan);
            check("fill_stable", fill_unstable, 1'b0);
        end
        @(posedge clk);
        @(negedge clk);
        check("resp_one_cycle", bus.resp_valid, 1'b0);
        check("req_ready_after", bus.req_ready, 1'b1);
        check_perm();
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            issue(vecs[i].set, vecs[i].tag, vecs[i].wr, vecs[i].hit, vecs[i].chan,
                  vecs[i].wb, vecs[i].wb_tag, 0, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        age_vec_t exp_ages;
        int       waited;

        // Set 0: eight clean misses fill channels 7 down to 0 (idx 0..7).
        for (int i = 0; i < 8; i++) add(4'd0, 8'hA0 + 8'(i), 1'b0, 1'b0, 3'(7 - i), 1'b0, 8'h00);
        // Set 3: fill tags 0x10..0x17 (idx 8..15), then hit 0x10 on channel 7 (idx 16).
        for (int i = 0; i < 8; i++) add(4'd3, 8'h10 + 8'(i), 1'b0, 1'b0, 3'(7 - i), 1'b0, 8'h00);
        add(4'd3, 8'h10, 1'b0, 1'b1, 3'd7, 1'b0, 8'h00);
        // Set 3: write hit on channel 2 (tag 0x15), then seven clean misses (idx 17..24).
        add(4'd3, 8'h15, 1'b1, 1'b1, 3'd2, 1'b0, 8'h00);
        add(4'd3, 8'h20, 1'b0, 1'b0, 3'd6, 1'b0, 8'h00);
        add(4'd3, 8'h21, 1'b0, 1'b0, 3'd5, 1'b0, 8'h00);
        add(4'd3, 8'h22, 1'b0, 1'b0, 3'd4, 1'b0, 8'h00);
        add(4'd3, 8'h23, 1'b0, 1'b0, 3'd3, 1'b0, 8'h00);
        add(4'd3, 8'h24, 1'b0, 1'b0, 3'd1, 1'b0, 8'h00);
        add(4'd3, 8'h25, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
        add(4'd3, 8'h26, 1'b0, 1'b0, 3'd7, 1'b0, 8'h00);
        // Set 1: dirty fill on ch7, seven clean fills, dirty eviction with ready already high (idx 25..34).
        add(4'd1, 8'h31, 1'b1, 1'b0, 3'd7, 1'b0, 8'h00);
        for (int i = 0; i < 7; i++) add(4'd1, 8'h32 + 8'(i), 1'b0, 1'b0, 3'(6 - i), 1'b0, 8'h00);
        add(4'd1, 8'h39, 1'b0, 1'b0, 3'd7, 1'b1, 8'h31);
        add(4'd1, 8'h32, 1'b0, 1'b1, 3'd6, 1'b0, 8'h00);

        bus.req_valid = 1'b0; bus.req_set = '0; bus.req_tag = '0; bus.req_write = 1'b0;
        bus.wb_ready = 1'b0; bus.fill_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_wb_valid", bus.wb_valid, 1'b0);
        check("rst_fill_valid", bus.fill_valid, 1'b0);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_fill_tag", bus.fill_tag, 8'h00);
        rst = 1'b0;

        run_range(0, 16);
        exp_ages = {3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        check("set3_ages_after_hit", dut.age_mem[3], exp_ages);

        run_range(17, 24);
        // Channel 2 is now oldest and dirty: writeback stalls 10 cycles, then fill.
        issue(4'd3, 8'h27, 1'b0, 1'b0, 3'd2, 1'b1, 8'h15, 10, 0);
        exp_ages = {3'd1, 3'd7, 3'd6, 3'd5, 3'd4, 3'd0, 3'd3, 3'd2};
        check("set3_ages_after_wb", dut.age_mem[3], exp_ages);

        run_range(25, 34);

        // Set isolation: a miss to set 5 leaves set 6 untouched.
        issue(4'd6, 8'h66, 1'b0, 1'b0, 3'd7, 1'b0, 8'h00, 0, 0);
        issue(4'd5, 8'h55, 1'b0, 1'b0, 3'd7, 1'b0, 8'h00, 0, 0);
        exp_ages = {3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        check("set6_ages_kept", dut.age_mem[6], exp_ages);
        check("set6_tag_kept", dut.tag_mem[6][7], 8'h66);
        check("set6_valid_kept", dut.valid_mem[6], 8'h80);
        issue(4'd6, 8'h66, 1'b0, 1'b1, 3'd7, 1'b0, 8'h00, 0, 0);

        // Reset while a fill is pending.
        bus.req_valid = 1'b1; bus.req_set = 4'd0; bus.req_tag = 8'hB0; bus.req_write = 1'b0;
        bus.fill_ready = 1'b0; bus.wb_ready = 1'b0;
        waited = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            bus.req_valid = 1'b0;
            waited++;
        end while (!bus.fill_valid && waited < 20);
        check("fill_before_rst", bus.fill_valid, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_fill_valid", bus.fill_valid, 1'b0);
        check("midrst_wb_valid", bus.wb_valid, 1'b0);
        check("midrst_resp_valid", bus.resp_valid, 1'b0);
        check("midrst_req_ready", bus.req_ready, 1'b1);
        check("midrst_fill_chan", bus.fill_chan, 3'd0);
        exp_ages = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        check("midrst_set0_ages", dut.age_mem[0], exp_ages);
        check("midrst_set3_ages", dut.age_mem[3], exp_ages);
        check("midrst_set3_valid", dut.valid_mem[3], 8'h00);
        rst = 1'b0;

        // Former resident tag now misses; second miss holds fill_ready low 3 cycles.
        issue(4'd3, 8'h10, 1'b0, 1'b0, 3'd7, 1'b0, 8'h00, 0, 0);
        issue(4'd3, 8'h11, 1'b1, 1'b0, 3'd6, 1'b0, 8'h00, 0, 3);
        issue(4'd3, 8'h11, 1'b0, 1'b1, 3'd6, 1'b0, 8'h00, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/cache_replace_ctrl.md
# cache_replace_ctrl

Sequential replacement controller for one 8-channel set-associative cache array. Holds per-set tag, valid, modified and 3-bit LRU age for every channel, and serialises each lookup request through hit detection, victim selection, dirty-victim writeback and line fill. Ages are updated with the true-LRU rule. The victim is always the channel whose age equals the maximum LRU value, 3'b111. Sits between the cache front end (request side) and the memory interface (writeback/fill side).

## Interface
- `SET_COUNT`, 16: number of sets; must be a power of two.
- `SET_WIDTH`, 4: log2(SET_COUNT).
- `TAG_WIDTH`, 8: tag width.
- `CHAN_COUNT`, 8: channels per set; fixed at 8, with CHAN_WIDTH = LRU_WIDTH = 3.

- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  lookup request present.
- `req_ready`  out  1  controller can accept a request; high only in IDLE.
- `req_set`  in  SET_WIDTH  set index.
- `req_tag`  in  TAG_WIDTH  tag.
- `req_write`  in  1  access is a store; marks the line modified.
- `wb_valid`  out  1  dirty-victim writeback request.
- `wb_ready`  in  1  memory accepts the writeback.
- `wb_set`  out  SET_WIDTH  set index of the victim.
- `wb_tag`  out  TAG_WIDTH  tag of the victim.
- `wb_chan`  out  CHAN_WIDTH  channel of the victim.
- `fill_valid`  out  1  line-fill request for the missed tag.
- `fill_ready`  in  1  fill data delivered.
- `fill_set`  out  SET_WIDTH  set index for the fill.
- `fill_tag`  out  TAG_WIDTH  tag being filled.
- `fill_chan`  out  CHAN_WIDTH  channel being filled.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_hit`  out  1  the request hit.
- `resp_chan`  out  CHAN_WIDTH  channel now holding the line.

## Operation
- **Reset**
  - Every set: valid=0, mod=0, tag=0, age[w]=w, so channel 7 is the oldest.
  - FSM goes to IDLE.
  - All valid outputs are 0; all data outputs are 0.
- **States:** IDLE, LOOKUP, WB, FILL, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid, latch set, tag and write, then go to LOOKUP.
- **LOOKUP** (1 cycle)
  - Hit means exactly one channel has valid=1 and a matching tag.
  - Hit: touch that channel, set mod|=req_write, go to RESP with resp_hit=1.
  - Miss: the victim is the unique channel with age==3'b111.
    - If the victim has valid&mod, go to WB.
    - Otherwise go to FILL.
- **WB**
  - wb_valid=1 with the victim's set, tag and channel, held stable until wb_ready.
  - On the handshake, clear the victim's mod bit and go to FILL.
- **FILL**
  - fill_valid=1 with the set, the latched tag and the victim channel, held until fill_ready.
  - On the handshake: tag=latched tag, valid=1, mod=req_write, touch the channel, go to RESP with resp_hit=0.
- **RESP**
  - resp_valid=1 for exactly one cycle with resp_hit and resp_chan, then go to IDLE.
- **Touch rule** for channel k with old age a:
  - Every channel in the set with age < a increments by 1.
  - Channel k becomes 0.
  - Other channels are unchanged.
  - The ages of a set always remain a permutation of 0..7. There is no wrap-around, and no age ever exceeds 7.
- Only the addressed set is modified. Other sets are untouched.
- Ready held high in WB/FILL for many cycles: valid stays asserted and the outputs stay stable.
- Ready present in the same cycle as valid first asserts: the handshake completes in that cycle.
- **Reset mid-operation:** rst in any state aborts the request and clears all valid outputs on the next edge. Array contents are reinitialised.

## Timing
- Request accepted at edge 0. Hit: resp_valid is high in the cycle after edge 2 (LOOKUP at edge 1, RESP at edge 2).
- Clean miss:
  - fill_valid rises after edge 2.
  - resp_valid rises one cycle after the fill handshake.
- Dirty miss: after edge 2 wb_valid rises; FILL starts the cycle after the wb handshake.
- Throughput: one request in flight. req_ready is low from acceptance until RESP has completed.
- All outputs are registered, or decoded from the registered state and registered fields. There is no combinational path from any input to any output.

## Structure
- Shared package `cache_pkg`:
  - constants CHAN_COUNT, CHAN_WIDTH, LRU_WIDTH, MAX_LRU = 3'b111;
  - FSM state enum.
- Sub-module `lru_age_update`: combinational. Takes the 8 ages of one set plus the touched channel, and returns the 8 updated ages. It is reused by the hit path and the fill path.

## Test plan
- Reset, then read set 0 via misses: the first miss fills channel 7, the next fills channel 6, and so on down to 0. Eight fills, with no wb_valid.
- Fill set 3 with tags 0x10..0x17, then read tag 0x10 → resp_hit=1, resp_chan=7 at cycle 2. Ages: ch7=0, ch0..6 incremented.
- Write hit on channel 2 of a full set, then force that line to become the victim → wb_valid with wb_chan=2 and the correct tag, then fill.
- Hold wb_ready=0 for 10 cycles in WB → wb_valid and wb_* stay stable, and req_ready stays 0.
- Miss to set 5 while set 6 holds state → set 6 tags and ages are unchanged. Assert the permutation invariant on every set after every response.
- Assert rst during FILL → next cycle all valids are 0, req_ready=1, and set ages are back to 0..7 by channel index.
